// File: rtl/sram_arb_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// sram_arb_pkg : access states, default widths and per-state SRAM strobe decode (rev 1.0)
//----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int c_ADDR_W = 11;
  localparam int c_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic ncs;
    logic noe;
    logic rnw;
    logic drv;
  } strobe_t;

  localparam strobe_t c_IDLE_STROBES = '{ncs: 1'b1, noe: 1'b1, rnw: 1'b1, drv: 1'b0};

  // Strobe pattern the SRAM pins must show while the FSM sits in state s.
  function automatic strobe_t strobes_for(input state_e s, input logic we);
    strobe_t st;
    st = c_IDLE_STROBES;
    case (s)
      S_SETUP: begin
        st.ncs = 1'b0;
        st.noe = we;
        st.drv = we;
      end
      S_READ: begin
        st.ncs = 1'b0;
        st.noe = 1'b0;
      end
      S_WRITE: begin
        st.ncs = 1'b0;
        st.rnw = 1'b0;
        st.drv = 1'b1;
      end
      S_HOLD: begin
        st.ncs = 1'b0;
        st.drv = 1'b1;
      end
      default: st = c_IDLE_STROBES;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_rr_arb2.sv
`default_nettype none
//----------------------------------------------------------------------------
// sram_rr_arb2 : two-input round-robin arbiter, pointer advances on accept (rev 1.0)
//----------------------------------------------------------------------------
module sram_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_accept,
  output logic o_valid,
  output logic o_grant
);

  // Index of the port served last; reset to 1 so port 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_grant = ~r_last;
    end else begin
      o_grant = i_req1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_accept && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// sram_access_arbiter : shares one async SRAM between CPU PIO and refresh engine (rev 1.0)
//----------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int DATA_W  = c_DATA_W,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ncs,
  output logic              sram_noe,
  output logic              sram_rnw
);

  localparam int c_WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int c_CNT_W    = (c_WAIT_MAX > 1) ? $clog2(c_WAIT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_WAIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_e              r_state;
  state_e              w_nxt_state;
  strobe_t             r_strb;
  strobe_t             w_nxt_strb;
  logic                w_valid;
  logic                w_grant;
  logic                w_accept;
  logic                w_nxt_we;
  logic                r_sel;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  sram_rr_arb2 u_arb (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .i_req0   (req0),
    .i_req1   (req1),
    .i_accept (w_accept),
    .o_valid  (w_valid),
    .o_grant  (w_grant)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Strobes are decoded from the next state so the pins are registered and
  // fall back to their idle values the instant reset asserts.
  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_nxt_we    = r_we;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_nxt_state = S_SETUP;
          w_accept    = 1'b1;
          w_nxt_we    = w_grant ? we1 : we0;
        end
      end
      S_SETUP: w_nxt_state = r_we ? S_WRITE : S_READ;
      S_READ:  if (r_cnt == '0) w_nxt_state = S_DONE;
      S_WRITE: if (r_cnt == '0) w_nxt_state = S_HOLD;
      S_HOLD:  w_nxt_state = S_DONE;
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    w_nxt_strb = strobes_for(w_nxt_state, w_nxt_we);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_strb   <= c_IDLE_STROBES;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_strb <= w_nxt_strb;
      r_ack0 <= (w_nxt_state == S_DONE) && !r_sel;
      r_ack1 <= (w_nxt_state == S_DONE) && r_sel;
      if (w_accept) begin
        r_sel   <= w_grant;
        r_we    <= w_nxt_we;
        r_addr  <= w_grant ? addr1 : addr0;
        r_wdata <= w_grant ? wdata1 : wdata0;
      end
      if (r_state == S_SETUP) begin
        r_cnt <= r_we ? c_WR_LOAD : c_RD_LOAD;
      end else if ((r_state == S_READ || r_state == S_WRITE) && r_cnt != '0) begin
        r_cnt <= r_cnt - c_CNT_ONE;
      end
      if (r_state == S_READ && r_cnt == '0) begin
        if (r_sel) begin
          r_rdata1 <= sram_data;
        end else begin
          r_rdata0 <= sram_data;
        end
      end
    end
  end

  assign sram_data = r_strb.drv ? r_wdata : {DATA_W{1'bz}};
  assign sram_addr = r_addr;
  assign sram_ncs  = r_strb.ncs;
  assign sram_noe  = r_strb.noe;
  assign sram_rnw  = r_strb.rnw;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;

endmodule
`default_nettype wire

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the board's single 2K x 8 asynchronous SRAM between two requesters: port 0 is the CPU PIO bridge and port 1 is the board/shots refresh engine.
- Round-robin arbitration; sequences each access through the correct chip-select, output-enable, read/write and data-drive timing.
- Returns read data and a one-cycle ack to the requester that was served.
- Sits between the processor-system PIO exports and the top-level SRAM pins.

Parameters:
- ADDR_W, 11, SRAM address width.
- DATA_W, 8, SRAM data width.
- RD_WAIT, 2, cycles output-enable is held after SETUP before read data is captured (>=1).
- WR_WAIT, 2, cycles the write strobe (read/write low) is held (>=1).

Ports:
- clk_clk  input  1  system clock.
- reset_reset_n  input  1  asynchronous active-low reset.
- req0, req1  input  1 each  access request; held until the matching ack.
- we0, we1  input  1 each  1 = write, 0 = read.
- addr0, addr1  input  ADDR_W each  access address.
- wdata0, wdata1  input  DATA_W each  write data.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata0, rdata1  output  DATA_W each  read data, valid while the matching ack is high, held until that port's next read.
- sram_addr  output  ADDR_W  SRAM address.
- sram_data  inout  DATA_W  SRAM data bus; driven only during write phases, otherwise high-Z.
- sram_ncs  output  1  chip select, active low.
- sram_noe  output  1  output enable, active low.
- sram_rnw  output  1  1 = read, 0 = write strobe.

Behaviour:
- Reset (async, immediate):
  - State IDLE; sram_ncs=1, sram_noe=1, sram_rnw=1, sram_addr=0, sram_data=Z.
  - ack0=ack1=0, rdata0=rdata1=0; round-robin pointer set so port 0 wins first.
- States: IDLE, SETUP, READ, WRITE, HOLD, DONE.
- IDLE:
  - All SRAM strobes inactive, bus Z; IDLE is always occupied for at least 1 cycle between accesses (bus turnaround).
  - On a clock edge with any req high: winner chosen, and its we/addr/wdata latched into internal registers. State goes to SETUP.
  - Arbitration: only one request pending, that port wins. Both pending, the port not served last wins; the pointer updates at grant.
- SETUP, 1 cycle:
  - ncs=0 and latched address driven.
  - Read: noe=0, rnw=1.
  - Write: noe=1, rnw=1, latched data driven onto sram_data.
  - Next state READ or WRITE.
- READ, RD_WAIT cycles:
  - noe=0, ncs=0.
  - sram_data captured on the edge ending the last READ cycle; next state DONE.
- WRITE, WR_WAIT cycles:
  - rnw=0, noe=1, data driven; next state HOLD.
- HOLD, 1 cycle:
  - rnw=1, data still driven, ncs=0 (data hold time); next state DONE.
- DONE, 1 cycle:
  - ncs=1, noe=1, bus Z.
  - Winner's ack=1; for a read, the captured byte is on that port's rdata.
  - Next state IDLE.
- Latency, measured from the edge sampling req in IDLE:
  - Read ack is high in cycle 2+RD_WAIT.
  - Write ack is high in cycle 3+WR_WAIT.
- Invariants:
  - sram_noe and sram_rnw are never low in the same cycle.
  - sram_data is never driven while sram_noe=0.
  - At most one ack is high per cycle.
- The latched request is used for the whole access:
  - Input changes after the grant are ignored.
  - Deasserting req before ack does not abort; the ack still pulses.
- A req still high in the cycle after ack is treated as a new request and goes through IDLE arbitration.
- Reset mid-access: the access is abandoned, outputs take reset values asynchronously, and no ack is issued for the abandoned request.

Decomposition:
- Shared package sram_arb_pkg holds:
  - the state enum;
  - default ADDR_W/DATA_W constants;
  - the IDLE strobe values (ncs, noe, rnw = 1).
- One sub-module, sram_rr_arb2: two-input round-robin arbiter with req0/req1 inputs, grant index output and a pointer update on an accept strobe.
- The tristate for sram_data lives in the top of this block and is controlled by a registered drive enable.

Test Plan:
1. Port 0 writes addr 0x7FF, data 0xA5 (WR_WAIT=2) -> rnw low exactly 2 cycles; sram_data=0xA5 from SETUP through HOLD; ack0 high in cycle 5.
2. Port 1 reads addr 0x7FF (RD_WAIT=2) -> noe low 3 cycles (SETUP + 2); ack1 high in cycle 4 with rdata1=0xA5; rdata1 still 0xA5 after ack.
3. req0 and req1 rise together after reset -> port 0 is served first, then port 1 after one IDLE cycle with all strobes high and bus Z.
4. req0 held high continuously while port 1 requests -> grants alternate 0,1,0,1; port 1 is never starved.
5. Read immediately followed by a write -> an IDLE cycle with noe=1 and sram_data=Z separates them; the noe/rnw-both-low assertion never fires.
6. reset_reset_n pulled low during WRITE -> rnw, noe, ncs go to 1 and bus to Z without waiting for a clock; no ack after release; the next req0 completes normally.
